// File: rtl/ladybird_config.sv
// Shared arbiter state encoding and default watchdog timeout.
// Imported by the bus arbiter, and usable by the crossbar.
package ladybird_config;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } arb_state_t;

    localparam int ARB_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/ladybird_rr_picker.sv
// Round-robin picker: the first set req bit at or after last+1, modulo N.
// Purely combinational, with no backpressure; the caller decides when to advance last.
module ladybird_rr_picker #(
    parameter int N = 2,
    localparam int LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [LW-1:0] winner,
    output logic          any
);

    logic [LW-1:0] cand;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        cand   = '0;
        // off = N wraps back to last itself, so it is only chosen when it is the only requester
        for (int off = 1; off <= N; off++) begin
            cand = LW'((int'(last) + off) % N);
            if (!any && req[cand]) begin
                any    = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/ladybird_bus_arbiter.sv
// Round-robin arbiter that gives N masters one outstanding access at a time to a single target.
// The grant comes in the request cycle, the response 1 cycle after s_rvalid, and an optional watchdog returns an error.
module ladybird_bus_arbiter
    import ladybird_config::*;
#(
    parameter int N_MASTER       = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_MASTER-1:0]          m_req,
    input  logic [N_MASTER*ADDR_W-1:0]   m_addr,
    input  logic [N_MASTER-1:0]          m_we,
    input  logic [N_MASTER*DATA_W-1:0]   m_wdata,
    input  logic [N_MASTER*DATA_W/8-1:0] m_wstrb,
    output logic [N_MASTER-1:0]          m_gnt,
    output logic [N_MASTER-1:0]          m_rvalid,
    output logic [DATA_W-1:0]            m_rdata,
    output logic                         m_err,
    output logic                         s_req,
    output logic [ADDR_W-1:0]            s_addr,
    output logic                         s_we,
    output logic [DATA_W-1:0]            s_wdata,
    output logic [DATA_W/8-1:0]          s_wstrb,
    input  logic                         s_gnt,
    input  logic                         s_rvalid,
    input  logic [DATA_W-1:0]            s_rdata,
    output logic                         busy,
    output logic [$clog2(N_MASTER)-1:0]  grant_id
);

    localparam int IDW    = $clog2(N_MASTER);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    arb_state_t        state_q, state_d;
    logic [IDW-1:0]    last_q, last_d;
    logic [IDW-1:0]    grant_id_q, grant_id_d;
    logic [ADDR_W-1:0] s_addr_q, s_addr_d;
    logic              s_we_q, s_we_d;
    logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
    logic [STRB_W-1:0] s_wstrb_q, s_wstrb_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [IDW-1:0]    winner;
    logic              any_req;

    ladybird_rr_picker #(.N(N_MASTER)) u_picker (
        .req    (m_req),
        .last   (last_q),
        .winner (winner),
        .any    (any_req)
    );

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        grant_id_d = grant_id_q;
        s_addr_d   = s_addr_q;
        s_we_d     = s_we_q;
        s_wdata_d  = s_wdata_q;
        s_wstrb_d  = s_wstrb_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        m_gnt      = '0;
        m_rvalid   = '0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    m_gnt[winner] = 1'b1;
                    s_addr_d      = m_addr[int'(winner)*ADDR_W +: ADDR_W];
                    s_we_d        = m_we[winner];
                    s_wdata_d     = m_wdata[int'(winner)*DATA_W +: DATA_W];
                    s_wstrb_d     = m_wstrb[int'(winner)*STRB_W +: STRB_W];
                    last_d        = winner;
                    grant_id_d    = winner;
                    state_d       = REQ;
                end
            end
            REQ: begin
                if (s_gnt) begin
                    cnt_d = '0;
                    // A zero-latency target answers in the accept cycle, so WAIT is skipped
                    if (s_rvalid) begin
                        rdata_d = s_rdata;
                        err_d   = 1'b0;
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (s_rvalid) begin
                    rdata_d = s_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                m_rvalid[grant_id_q] = 1'b1;
                state_d              = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= IDW'(N_MASTER - 1);
            grant_id_q <= '0;
            s_addr_q   <= '0;
            s_we_q     <= 1'b0;
            s_wdata_q  <= '0;
            s_wstrb_q  <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            grant_id_q <= grant_id_d;
            s_addr_q   <= s_addr_d;
            s_we_q     <= s_we_d;
            s_wdata_q  <= s_wdata_d;
            s_wstrb_q  <= s_wstrb_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign s_req    = (state_q == REQ);
    assign busy     = (state_q != IDLE);
    assign s_addr   = s_addr_q;
    assign s_we     = s_we_q;
    assign s_wdata  = s_wdata_q;
    assign s_wstrb  = s_wstrb_q;
    assign m_rdata  = rdata_q;
    assign m_err    = err_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_ladybird_bus_arbiter.sv
// Directed bench for ladybird_bus_arbiter: stimulus queues the expected grants and responses,
// and a negedge monitor pops and compares them whenever m_gnt or m_rvalid is active.
module tb_ladybird_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  m_req;
    logic [63:0] m_addr;
    logic [1:0]  m_we;
    logic [63:0] m_wdata;
    logic [7:0]  m_wstrb;
    logic [1:0]  m_gnt;
    logic [1:0]  m_rvalid;
    logic [31:0] m_rdata;
    logic        m_err;
    logic        s_req;
    logic [31:0] s_addr;
    logic        s_we;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_gnt;
    logic        s_rvalid;
    logic [31:0] s_rdata;
    logic        busy;
    logic [0:0]  grant_id;

    ladybird_bus_arbiter #(
        .N_MASTER(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .m_req(m_req), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err),
        .s_req(s_req), .s_addr(s_addr), .s_we(s_we), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        err;
    } resp_t;

    int    exp_gnt[$];
    resp_t exp_resp[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sreq();
        for (int i = 0; i < 16; i++) begin
            next_cyc();
            if (s_req) return;
        end
        check("s_req_timeout", s_req, 1);
    endtask

    // Target model: accepts gnt_dly cycles into REQ and answers rv_dly cycles after the accept
    task automatic serve(input int gnt_dly, input int rv_dly, input bit respond, input logic [31:0] data);
        repeat (gnt_dly) next_cyc();
        check("s_req_held", s_req, 1);
        s_gnt = 1'b1;
        if (respond && rv_dly == 0) begin
            s_rvalid = 1'b1;
            s_rdata  = data;
        end
        next_cyc();
        s_gnt    = 1'b0;
        s_rvalid = 1'b0;
        check("s_req_drop", s_req, 0);
        if (respond && rv_dly > 0) begin
            repeat (rv_dly - 1) next_cyc();
            s_rvalid = 1'b1;
            s_rdata  = data;
            next_cyc();
            s_rvalid = 1'b0;
        end
    endtask

    function automatic resp_t mk_resp(input int id, input logic [31:0] data, input logic err);
        resp_t r;
        r.id   = id;
        r.data = data;
        r.err  = err;
        return r;
    endfunction

    always @(negedge clk) begin
        int    g;
        resp_t r;
        if (!rst) begin
            if (m_gnt != 2'b00) begin
                if (exp_gnt.size() == 0) begin
                    check("unexpected_gnt", m_gnt, 0);
                end else begin
                    g = exp_gnt.pop_front();
                    check("gnt_onehot", m_gnt, 64'd1 << g);
                end
            end
            if (m_rvalid != 2'b00) begin
                if (exp_resp.size() == 0) begin
                    check("unexpected_rvalid", m_rvalid, 0);
                end else begin
                    r = exp_resp.pop_front();
                    check("rvalid_target", m_rvalid, 64'd1 << r.id);
                    check("rdata", m_rdata, r.data);
                    check("err", m_err, r.err);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not complete, got no finish, expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "global timeout");
    end

    initial begin
        rst = 1'b1; m_req = '0; m_addr = '0; m_we = '0; m_wdata = '0; m_wstrb = '0;
        s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
        repeat (3) next_cyc();
        rst = 1'b0;
        next_cyc();

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_s_req", s_req, 0);
        check("rst_m_gnt", m_gnt, 0);
        check("rst_m_rvalid", m_rvalid, 0);
        check("rst_m_err", m_err, 0);
        check("rst_m_rdata", m_rdata, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_s_addr", s_addr, 0);

        // Master 1 alone: accept in the 2nd REQ cycle, data 2 cycles after the accept
        m_req = 2'b10; m_addr[63:32] = 32'h9000_0010; m_we = 2'b00;
        exp_gnt.push_back(1);
        exp_resp.push_back(mk_resp(1, 32'hDEAD_BEEF, 1'b0));
        wait_sreq();
        m_req = 2'b00;
        check("t1_s_addr", s_addr, 32'h9000_0010);
        check("t1_s_we", s_we, 0);
        check("t1_grant_id", grant_id, 1);
        serve(1, 2, 1'b1, 32'hDEAD_BEEF);
        check("t1_rvalid_cycle5", m_rvalid, 2'b10);

        // Both masters contending: strict alternation starting from master 0
        m_addr = {32'h0000_2000, 32'h0000_1000};
        m_req  = 2'b11;
        for (int i = 0; i < 16; i++) begin
            exp_gnt.push_back(i % 2);
            exp_resp.push_back(mk_resp(i % 2, 32'hA5A5_0000 + 32'(i), 1'b0));
        end
        for (int i = 0; i < 16; i++) begin
            wait_sreq();
            check("t2_s_addr", s_addr, (i % 2 == 1) ? 32'h0000_2000 : 32'h0000_1000);
            serve(0, 1, 1'b1, 32'hA5A5_0000 + 32'(i));
        end

        // Master 0 write against a zero-latency target
        m_req = 2'b01; m_addr[31:0] = 32'h1000_0004; m_we = 2'b01;
        m_wdata[31:0] = 32'h1234_5678; m_wstrb[3:0] = 4'b0011;
        exp_gnt.push_back(0);
        exp_resp.push_back(mk_resp(0, 32'hC0DE_0001, 1'b0));
        wait_sreq();
        m_req = 2'b00;
        check("t3_s_addr", s_addr, 32'h1000_0004);
        check("t3_s_we", s_we, 1);
        check("t3_s_wdata", s_wdata, 32'h1234_5678);
        check("t3_s_wstrb", s_wstrb, 4'b0011);
        serve(0, 0, 1'b1, 32'hC0DE_0001);
        check("t3_rvalid_2_after_gnt", m_rvalid, 2'b01);

        // Watchdog: the target accepts but never answers
        m_req = 2'b10; m_addr[63:32] = 32'h2000_0000; m_we = 2'b00;
        exp_gnt.push_back(1);
        exp_resp.push_back(mk_resp(1, 32'h0, 1'b1));
        wait_sreq();
        m_req = 2'b00;
        serve(0, 0, 1'b0, 32'h0);
        repeat (7) next_cyc();
        check("t4_no_early_timeout", m_rvalid, 2'b00);
        check("t4_busy_waiting", busy, 1);
        next_cyc();
        check("t4_timeout_rvalid", m_rvalid, 2'b10);
        check("t4_timeout_err", m_err, 1);
        check("t4_timeout_rdata", m_rdata, 0);
        next_cyc();
        s_rvalid = 1'b1; s_rdata = 32'hBAD0_BAD0;
        next_cyc();
        s_rvalid = 1'b0;
        check("t4_late_ignored_busy", busy, 0);
        check("t4_late_ignored_rdata", m_rdata, 0);
        check("t4_late_ignored_err", m_err, 1);
        check("t4_late_ignored_rvalid", m_rvalid, 2'b00);

        // Reset in WAIT, after which master 0 must win again
        m_req = 2'b01; m_addr[31:0] = 32'h3000_0000;
        exp_gnt.push_back(0);
        wait_sreq();
        m_req = 2'b00;
        serve(0, 0, 1'b0, 32'h0);
        next_cyc();
        rst = 1'b1;
        next_cyc();
        check("t5_rst_busy", busy, 0);
        check("t5_rst_s_req", s_req, 0);
        check("t5_rst_rvalid", m_rvalid, 2'b00);
        rst = 1'b0;
        m_req = 2'b11;
        exp_gnt.push_back(0);
        exp_resp.push_back(mk_resp(0, 32'h5555_AAAA, 1'b0));
        wait_sreq();
        m_req = 2'b00;
        check("t5_grant_id", grant_id, 0);
        serve(0, 1, 1'b1, 32'h5555_AAAA);
        repeat (3) next_cyc();

        check("gnt_queue_empty", exp_gnt.size(), 0);
        check("resp_queue_empty", exp_resp.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
